mem_uart_bridge: RTL and testbench
==================================

# mem_uart_bridge

Memory-side stage directly downstream of the core's memory port. It decodes each core access into either a word-organised on-chip RAM with byte lanes or a small MMIO window holding a buffered UART transmitter. It returns right-aligned, zero-extended read data one cycle after the request. It flags misaligned accesses so the core-level trap logic can act on them.

## Interface
Parameters:
- MEM_WORDS, 4096: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: UART TX FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 868: clock cycles per UART bit; at least 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  32  byte address from core.
- mem_rden  in  1  read request, one cycle per access.
- mem_wren  in  1  write request, one cycle per access.
- mem_size  in  2  access size: 0 byte, 1 half, 2 word; 3 treated as word.
- memwrite_data  in  32  write data, right-aligned.
- memread_data  out  32  read data, right-aligned, zero-extended.
- uart_tx  out  1  serial output, 8N1, idle high.
- access_err  out  1  one-cycle pulse on a misaligned access.

## Operation
- Decode:
  - mem_addr[31:28]==4'h1 selects MMIO; everything else selects RAM.
  - RAM word index is mem_addr[log2(MEM_WORDS)+1:2]. Upper bits are ignored, so the RAM wraps (aliases) across the address space.
- Alignment:
  - A half access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]≠0 is misaligned.
  - A misaligned access has no side effect: no RAM write, no FIFO push, and memread_data is held.
- RAM write byte enables:
  - Byte: the lane is addr[1:0]; memwrite_data[7:0] is placed in that lane.
  - Half: lanes {addr[1],0} and {addr[1],1}; memwrite_data[15:0].
  - Word: all four lanes.
- RAM read: select the addressed lane(s), shift right to bit 0, zero-fill above.
- MMIO offsets (mem_addr[3:0]):
  - 0x0 TXDATA: a write pushes memwrite_data[7:0] into the FIFO; a read returns 0.
  - 0x4 STATUS: read returns {28'b0, tx_busy, overflow, fifo_full, fifo_empty} in bits [3:0]. A write with memwrite_data[2]=1 clears overflow.
  - Other offsets: reads return 0; writes are ignored.
- Priority: if mem_rden and mem_wren are both high, the write is performed and memread_data holds.
- FIFO:
  - A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - A rejected push sets the sticky overflow bit.
  - overflow set and clear in the same cycle: set wins.
- Transmitter FSM:
  - States: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop one byte into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. A 3-bit bit counter and a baud counter that counts 0..CLKS_PER_BIT-1 pace the bits.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - tx_busy = (state≠IDLE).
- Reset (async, immediate) drives:
  - memread_data=0, access_err=0, uart_tx=1.
  - FSM to IDLE; FIFO pointers and count to 0; overflow=0; baud and bit counters to 0.
  - RAM contents are not reset.
  - Reset asserted mid-frame aborts the frame; uart_tx returns high at once.

## Timing
- A read requested in cycle N: memread_data is updated at the edge ending cycle N and is valid throughout cycle N+1. It holds until the next successful read.
- RAM writes and FIFO pushes take effect at the edge ending the request cycle.
- A STATUS read in cycle N reflects state before that edge's push or pop.
- access_err is registered: high for exactly cycle N+1 after a misaligned request in cycle N.
- A push in cycle N into an empty FIFO with the FSM in IDLE:
  - The FSM pops at the end of cycle N+1.
  - uart_tx falls in cycle N+2.
- A full frame is 10·CLKS_PER_BIT cycles.
- Back-to-back bytes: IDLE is occupied for exactly one cycle between STOP and the next START.

## Test plan
- Word write 0xDEADBEEF to 0x100, then byte reads 0x100..0x103 -> 0xEF, 0xBE, 0xAD, 0xDE. Half read 0x102 -> 0x0000DEAD. Each value appears the cycle after its request.
- Byte write 0x5A to 0x201 over word 0x11223344 at 0x200 -> word read 0x11225A44. Word read of 0x200+4·MEM_WORDS also returns 0x11225A44 (wrap).
- Word read at 0x102 and half write at 0x105 -> access_err is a single-cycle pulse each time; RAM is unchanged; memread_data is held.
- CLKS_PER_BIT=4, write 0xA5 to 0x10000000 -> uart_tx samples every 4 cycles read 0, 1,0,1,0,0,1,0,1, 1. STATUS bit3 is 1 during the frame and 0 after.
- FIFO_DEPTH=4, six back-to-back TXDATA writes while busy -> five bytes transmitted (one popped immediately, four queued), STATUS=0xE after the sixth write. Writing STATUS with 0x4 clears bit2.
- Assert rst mid-DATA -> uart_tx=1, memread_data=0, STATUS reads 0x1 after release; RAM data written earlier is still readable.

Source files
------------

// File: rtl/mem_uart_bridge.sv
// mem_uart_bridge: decodes core memory accesses into a byte-lane RAM or a
// small MMIO window holding a FIFO-buffered 8N1 UART transmitter.
module mem_uart_bridge #(
  parameter int MEM_WORDS    = 4096,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rden,
  input  logic        mem_wren,
  input  logic [1:0]  mem_size,
  input  logic [31:0] memwrite_data,
  output logic [31:0] memread_data,
  output logic        uart_tx,
  output logic        access_err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // access decode
  logic          is_mmio, is_half, is_word, misaligned, wr_ok, rd_ok;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata_lanes;
  logic          unused_addr_bits;

  assign is_mmio    = (mem_addr[31:28] == 4'h1);
  assign is_half    = (mem_size == 2'd1);
  assign is_word    = mem_size[1];
  assign misaligned = (is_half & mem_addr[0]) | (is_word & (mem_addr[1:0] != 2'b00));
  assign wr_ok      = mem_wren & ~misaligned;
  assign rd_ok      = mem_rden & ~mem_wren & ~misaligned;
  assign widx       = mem_addr[AW+1:2];
  // upper address bits only alias the RAM
  assign unused_addr_bits = ^mem_addr[27:AW+2];

  // byte enables and lane-replicated write data for the RAM
  always_comb begin
    be          = 4'b1111;
    wdata_lanes = memwrite_data;
    if (is_half) begin
      be          = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata_lanes = {2{memwrite_data[15:0]}};
    end else if (!is_word) begin
      be          = 4'b0001 << mem_addr[1:0];
      wdata_lanes = {4{memwrite_data[7:0]}};
    end
  end

  // word RAM with per-byte write enables; contents are deliberately not reset
  logic [31:0] ram [MEM_WORDS];
  always_ff @(posedge clk) begin
    if (wr_ok && !is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[widx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  // TX FIFO and status
  tx_state_e     state_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          overflow_q;
  logic          fifo_empty, fifo_full, tx_busy, pop, push_req, push, ovf_set, ovf_clr;
  logic [31:0]   status, mmio_rdata;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign tx_busy    = (state_q != S_IDLE);
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  assign push_req   = wr_ok & is_mmio & (mem_addr[3:0] == 4'h0);
  // a full FIFO still accepts a push when the transmitter drains a slot this cycle
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & ~push;
  assign ovf_clr    = wr_ok & is_mmio & (mem_addr[3:0] == 4'h4) & memwrite_data[2];
  assign status     = {28'b0, tx_busy, overflow_q, fifo_full, fifo_empty};
  assign mmio_rdata = (mem_addr[3:0] == 4'h4) ? status : 32'h0;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= memwrite_data[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      overflow_q <= ovf_set | (overflow_q & ~ovf_clr);
    end
  end

  // read capture: raw word plus lane/size, formatted on the way out
  logic [31:0] rd_word_q;
  logic [1:0]  rd_off_q, rd_size_q;
  logic        err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_word_q <= '0;
      rd_off_q  <= '0;
      rd_size_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (mem_rden | mem_wren) & misaligned;
      if (rd_ok) begin
        rd_word_q <= is_mmio ? mmio_rdata : ram[widx];
        rd_off_q  <= mem_addr[1:0];
        rd_size_q <= mem_size;
      end
    end
  end

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  assign half_sel     = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
  assign byte_sel     = rd_off_q[0] ? half_sel[15:8] : half_sel[7:0];
  assign memread_data = rd_size_q[1] ? rd_word_q :
                        (rd_size_q[0] ? {16'h0, half_sel} : {24'h0, byte_sel});
  assign access_err   = err_q;

  // transmitter FSM: 8N1 framing paced by baud and bit counters
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q <= fifo_q[rd_ptr_q];
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;
endmodule

// File: tb/tb_mem_uart_bridge.sv
// tb_mem_uart_bridge: directed accesses against a cycle-level reference model,
// plus literal expectations and a serial receiver for the UART line.
module tb_mem_uart_bridge;
  localparam int MW  = 256;
  localparam int FD  = 4;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_rden = 1'b0;
  logic        mem_wren = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [31:0] memwrite_data = '0;
  logic [31:0] memread_data;
  logic        uart_tx;
  logic        access_err;

  always #5 clk = ~clk;

  mem_uart_bridge #(.MEM_WORDS(MW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_size(mem_size), .memwrite_data(memwrite_data), .memread_data(memread_data),
    .uart_tx(uart_tx), .access_err(access_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mram [int];
  logic [7:0]  mq [$];
  logic        m_ovf, m_err, m_active;
  logic [31:0] m_rd;
  logic [7:0]  m_byte;
  int          cyc = 0;
  int          tx_start = 0;

  function automatic logic m_busy(input int c);
    return m_active && (c >= tx_start) && (c < tx_start + 10*CPB);
  endfunction

  function automatic logic m_tx(input int c);
    int k;
    if (!m_busy(c)) return 1'b1;
    k = (c - tx_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] m_status(input int c);
    return {28'b0, m_busy(c), m_ovf, (mq.size() == FD), (mq.size() == 0)};
  endfunction

  function automatic logic [31:0] m_word(input int idx);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) w[8*l +: 8] = mram.exists(idx*4+l) ? mram[idx*4+l] : 8'h00;
    return w;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] s;
    s = w >> (8*off);
    if (sz == 2'd0) return s & 32'h0000_00FF;
    if (sz == 2'd1) return s & 32'h0000_FFFF;
    return w;
  endfunction

  logic        mm_mis, mm_mmio, mm_pop, mm_push, mm_clr, mm_full, mm_ovfset;
  logic [1:0]  mm_off;
  int          mm_c, mm_idx;
  logic [31:0] mm_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_err = 1'b0; m_rd = '0; m_active = 1'b0;
    end else begin
      mm_c    = cyc;
      mm_mis  = (mem_size == 2'd1 && mem_addr[0]) || (mem_size >= 2'd2 && mem_addr[1:0] != 2'b00);
      mm_mmio = (mem_addr[31:28] == 4'h1);
      mm_idx  = int'((mem_addr >> 2) % MW);
      mm_full = (mq.size() == FD);
      mm_pop  = !m_busy(mm_c) && (mq.size() > 0);
      m_err   = (mem_rden || mem_wren) && mm_mis;
      mm_push = 1'b0; mm_clr = 1'b0;
      if (!mm_mis && mem_wren) begin
        if (mm_mmio) begin
          mm_push = (mem_addr[3:0] == 4'h0);
          mm_clr  = (mem_addr[3:0] == 4'h4) && memwrite_data[2];
        end else if (mem_size == 2'd0) begin
          mram[mm_idx*4 + int'(mem_addr[1:0])] = memwrite_data[7:0];
        end else if (mem_size == 2'd1) begin
          mm_off = {mem_addr[1], 1'b0};
          mram[mm_idx*4 + int'(mm_off)]     = memwrite_data[7:0];
          mram[mm_idx*4 + int'(mm_off) + 1] = memwrite_data[15:8];
        end else begin
          for (int l = 0; l < 4; l++) mram[mm_idx*4+l] = memwrite_data[8*l +: 8];
        end
      end else if (!mm_mis && mem_rden) begin
        if (mm_mmio) mm_v = (mem_addr[3:0] == 4'h4) ? m_status(mm_c) : 32'h0;
        else         mm_v = m_word(mm_idx);
        m_rd = m_fmt(mm_v, mem_addr[1:0], mem_size);
      end
      if (mm_pop) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        tx_start = mm_c + 1;
      end
      mm_ovfset = mm_push && mm_full && !mm_pop;
      if (mm_push && !mm_ovfset) mq.push_back(memwrite_data[7:0]);
      m_ovf = mm_ovfset | (m_ovf & ~mm_clr);
      cyc++;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("rdata", memread_data, m_rd);
      chk("access_err", 32'(access_err), 32'(m_err));
      chk("uart_tx", 32'(uart_tx), 32'(m_tx(cyc)));
    end
  end

  // serial receiver: samples mid-bit, collects decoded bytes
  logic [7:0] rx_q [$];
  logic [7:0] rx_b;
  always begin
    @(negedge clk);
    if (!rst && cmp_en && uart_tx == 1'b0) begin
      repeat (CPB/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      rx_q.push_back(rx_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [1:0] sz, input logic [31:0] d);
    mem_addr = a; mem_rden = rd; mem_wren = wr; mem_size = sz; memwrite_data = d;
    @(posedge clk); #1;
    mem_rden = 1'b0; mem_wren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    acc(1'b0, 1'b1, a, sz, d);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] exp);
    acc(1'b1, 1'b0, a, sz, 32'h0);
    chk(nm, memread_data, exp);
  endtask

  localparam logic [31:0] TXD  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;
  logic [9:0] a5_bits;
  int         polls;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", memread_data, 32'h0);
    chk("reset_tx", 32'(uart_tx), 32'h1);
    chk("reset_err", 32'(access_err), 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;
    rd_chk("reset_status", STAT, 2'd2, 32'h1);

    // byte lanes and right alignment
    wr(32'h100, 2'd2, 32'hDEAD_BEEF);
    rd_chk("rd_b0", 32'h100, 2'd0, 32'h0000_00EF);
    rd_chk("rd_b1", 32'h101, 2'd0, 32'h0000_00BE);
    rd_chk("rd_b2", 32'h102, 2'd0, 32'h0000_00AD);
    rd_chk("rd_b3", 32'h103, 2'd0, 32'h0000_00DE);
    rd_chk("rd_h2", 32'h102, 2'd1, 32'h0000_DEAD);

    // partial write and wrap
    wr(32'h200, 2'd2, 32'h1122_3344);
    wr(32'h201, 2'd0, 32'h0000_005A);
    rd_chk("rd_merge", 32'h200, 2'd2, 32'h1122_5A44);
    rd_chk("rd_wrap", 32'h200 + 4*MW, 2'd2, 32'h1122_5A44);
    wr(32'h206, 2'd1, 32'h0000_BEEF);
    rd_chk("rd_hwr", 32'h204, 2'd2, 32'hBEEF_0000 | m_word(int'(32'h204 >> 2)) & 32'h0000_FFFF);

    // misalignment: pulse, no side effect, data held
    wr(32'h104, 2'd2, 32'hCAFE_F00D);
    rd_chk("rd_pre_mis", 32'h100, 2'd2, 32'hDEAD_BEEF);
    acc(1'b1, 1'b0, 32'h102, 2'd2, 32'h0);
    chk("mis_rd_err", 32'(access_err), 32'h1);
    chk("mis_rd_hold", memread_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("mis_rd_pulse", 32'(access_err), 32'h0);
    acc(1'b0, 1'b1, 32'h105, 2'd1, 32'h0000_FFFF);
    chk("mis_wr_err", 32'(access_err), 32'h1);
    @(posedge clk); #1;
    chk("mis_wr_pulse", 32'(access_err), 32'h0);
    rd_chk("mis_wr_noeff", 32'h104, 2'd2, 32'hCAFE_F00D);
    rd_chk("size3_word", 32'h104, 2'd3, 32'hCAFE_F00D);
    acc(1'b1, 1'b1, 32'h104, 2'd2, 32'h1234_5678);
    chk("rdwr_hold", memread_data, 32'hCAFE_F00D);
    rd_chk("rdwr_wrote", 32'h104, 2'd2, 32'h1234_5678);

    // single frame 0xA5
    a5_bits = {1'b1, 8'hA5, 1'b0};
    rx_q.delete();
    wr(TXD, 2'd0, 32'h0000_00A5);
    fork
      begin
        @(negedge clk);
        chk("tx_idle_n1", 32'(uart_tx), 32'h1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("tx_a5_bit", 32'(uart_tx), 32'(a5_bits[i]));
          if (i < 9) repeat (CPB-1) @(negedge clk);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        rd_chk("status_busy", STAT, 2'd2, 32'h9);
      end
    join
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    rd_chk("status_done", STAT, 2'd2, 32'h1);
    chk("rx_a5_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) chk("rx_a5_byte", 32'(rx_q[0]), 32'h0000_00A5);

    // FIFO fill and overflow
    rx_q.delete();
    for (int i = 0; i < 6; i++) wr(TXD, 2'd0, 32'h30 + i);
    rd_chk("status_ovf", STAT, 2'd2, 32'hE);
    wr(STAT, 2'd2, 32'h4);
    rd_chk("status_clr", STAT, 2'd2, 32'hA);
    polls = 0;
    do begin
      acc(1'b1, 1'b0, STAT, 2'd2, 32'h0);
      polls++;
    end while (memread_data != 32'h1 && polls < 400);
    chk("fifo_drain", memread_data, 32'h1);
    chk("rx_fifo_count", 32'(rx_q.size()), 32'd5);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("rx_fifo_byte", 32'(rx_q[i]), 32'h30 + i);

    // reset in the middle of a frame
    rd_chk("rd_before_rst", 32'h200, 2'd2, 32'h1122_5A44);
    wr(TXD, 2'd0, 32'h0000_003C);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("pre_rst_in_frame", 32'(dut.tx_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_tx", 32'(uart_tx), 32'h1);
    chk("rst_rdata", memread_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_chk("rst_status", STAT, 2'd2, 32'h1);
    rd_chk("rst_ram_kept", 32'h200, 2'd2, 32'h1122_5A44);
    rd_chk("rst_ram_byte", 32'h101, 2'd0, 32'h0000_00BE);
    repeat (20) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
